// File: rtl/solver_pkg.sv
// Shared widths for the clause-side blocks of the MCMC constraint solver.
// Everything downstream derives its port and field sizes from these constants.
package solver_pkg;

    localparam int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1;
    localparam int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1;
    localparam int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4;
    localparam int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2;

    // Slot counts per clause and per-slot field widths
    localparam int NI = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
    localparam int NB = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int WI = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
    localparam int WB = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;

    // One extra bit so a count of every slot (NI or NB) still fits
    localparam int CI = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX + 1;
    localparam int CB = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX + 1;

endpackage

// File: rtl/variables_detector_if.sv
// Clause-coefficient request and variable-presence result between clause fetch and
// variable selection.
// Handshake: a request is taken on every rising edge where in_valid=1 (no ready, no
// backpressure); out_valid pulses for one cycle exactly one edge later, and the result
// fields hold their last value while out_valid=0.
interface variables_detector_if;
    import solver_pkg::*;

    logic               in_valid;
    logic [NI*WI-1:0]   in_integer_coefficients;
    logic [NB*WB-1:0]   in_boolean_coefficients;
    logic               out_valid;
    logic [NI-1:0]      out_integer_variables;
    logic [NB-1:0]      out_boolean_variables;
    logic [CI-1:0]      out_integer_count;
    logic [CB-1:0]      out_boolean_count;

    modport master (
        output in_valid,
        output in_integer_coefficients,
        output in_boolean_coefficients,
        input  out_valid,
        input  out_integer_variables,
        input  out_boolean_variables,
        input  out_integer_count,
        input  out_boolean_count
    );

    modport slave (
        input  in_valid,
        input  in_integer_coefficients,
        input  in_boolean_coefficients,
        output out_valid,
        output out_integer_variables,
        output out_boolean_variables,
        output out_integer_count,
        output out_boolean_count
    );

endinterface

// File: rtl/field_nonzero_detector.sv
// Combinational mask of which of N packed W-bit fields are non-zero.
// Pure OR-reduction: sign and encoding of a field are deliberately ignored.
module field_nonzero_detector #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic [N*W-1:0] in_fields,
    output logic [N-1:0]   out_mask
);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_slot
            assign out_mask[g] = |in_fields[g*W +: W];
        end
    endgenerate

endmodule

// File: rtl/variables_detector.sv
// Flags which integer and boolean variables appear in one clause, with their counts,
// registered one cycle behind the valid-tagged coefficient input.
module variables_detector
    import solver_pkg::*;
(
    input  logic               in_clk,
    input  logic               in_reset,
    variables_detector_if.slave vd
);

    logic [NI-1:0] w_integer_mask;
    logic [NB-1:0] w_boolean_mask;
    logic [CI-1:0] w_integer_count;
    logic [CB-1:0] w_boolean_count;

    logic          r_valid;
    logic [NI-1:0] r_integer_variables;
    logic [NB-1:0] r_boolean_variables;
    logic [CI-1:0] r_integer_count;
    logic [CB-1:0] r_boolean_count;

    field_nonzero_detector #(
        .N (NI),
        .W (WI)
    ) u_integer_detector (
        .in_fields (vd.in_integer_coefficients),
        .out_mask  (w_integer_mask)
    );

    // Reserved literal 2'b10 is reported as present: no decode, only OR-reduction
    field_nonzero_detector #(
        .N (NB),
        .W (WB)
    ) u_boolean_detector (
        .in_fields (vd.in_boolean_coefficients),
        .out_mask  (w_boolean_mask)
    );

    always_comb begin
        w_integer_count = '0;
        for (int i = 0; i < NI; i++) begin
            w_integer_count = w_integer_count + CI'(w_integer_mask[i]);
        end
    end

    always_comb begin
        w_boolean_count = '0;
        for (int j = 0; j < NB; j++) begin
            w_boolean_count = w_boolean_count + CB'(w_boolean_mask[j]);
        end
    end

    // Masks and counts update together, so counts always match the vectors beside them
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_valid             <= 1'b0;
            r_integer_variables <= '0;
            r_boolean_variables <= '0;
            r_integer_count     <= '0;
            r_boolean_count     <= '0;
        end else begin
            r_valid <= vd.in_valid;
            if (vd.in_valid) begin
                r_integer_variables <= w_integer_mask;
                r_boolean_variables <= w_boolean_mask;
                r_integer_count     <= w_integer_count;
                r_boolean_count     <= w_boolean_count;
            end
        end
    end

    assign vd.out_valid             = r_valid;
    assign vd.out_integer_variables = r_integer_variables;
    assign vd.out_boolean_variables = r_boolean_variables;
    assign vd.out_integer_count     = r_integer_count;
    assign vd.out_boolean_count     = r_boolean_count;

endmodule

// File: tb/tb_variables_detector.sv
// Bench for variables_detector: directed spec vectors plus randomized traffic
// compared against a slot-by-slot arithmetic reference model.
module tb_variables_detector;
    import solver_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Reference model state (what the outputs should show after the last edge)
    logic       m_valid;
    logic [1:0] m_iv;
    logic [1:0] m_bv;
    logic [1:0] m_ic;
    logic [1:0] m_bc;

    variables_detector_if vif ();

    variables_detector dut (
        .in_clk   (clk),
        .in_reset (rst),
        .vd       (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the rising edge take them, advance the model,
    // then settle #1 past the edge for sampling.
    task automatic apply(input logic r, input logic v, input logic [7:0] iv, input logic [3:0] bv);
        int ic;
        int bc;
        int f;
        logic [1:0] im;
        logic [1:0] bm;
        rst = r;
        vif.in_valid = v;
        vif.in_integer_coefficients = iv;
        vif.in_boolean_coefficients = bv;
        @(posedge clk);
        ic = 0;
        bc = 0;
        im = '0;
        bm = '0;
        for (int i = 0; i < 2; i++) begin
            f = (int'(iv) >> (i * 4)) % 16;
            if (f != 0) begin
                im[i] = 1'b1;
                ic = ic + 1;
            end
            f = (int'(bv) >> (i * 2)) % 4;
            if (f != 0) begin
                bm[i] = 1'b1;
                bc = bc + 1;
            end
        end
        if (r) begin
            m_valid = 1'b0;
            m_iv = '0;
            m_bv = '0;
            m_ic = '0;
            m_bc = '0;
        end else if (v) begin
            m_valid = 1'b1;
            m_iv = im;
            m_bv = bm;
            m_ic = 2'(ic);
            m_bc = 2'(bc);
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        apply(1'b1, 1'b0, 8'h00, 4'h0);
        apply(1'b1, 1'b1, 8'hFF, 4'hF);
        got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'd0) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", got, 9'd0);
        end
    endtask

    task automatic test_directed();
        logic [7:0] d_int [6] = '{8'h11, 8'h03, 8'hF0, 8'h00, 8'h80, 8'h08};
        logic [3:0] d_bool[6] = '{4'b0111, 4'b0001, 4'b1000, 4'b0000, 4'b1100, 4'b0010};
        logic [8:0] d_exp [6] = '{9'b1_11_11_10_10, 9'b1_01_01_01_01, 9'b1_10_10_01_01,
                                  9'b1_00_00_00_00, 9'b1_10_10_01_01, 9'b1_01_01_01_01};
        logic [8:0] got;
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 1'b1, d_int[k], d_bool[k]);
            got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
                   vif.out_integer_count, vif.out_boolean_count};
            total++;
            if (got !== d_exp[k]) begin
                bad++;
                $display("FAIL directed_%0d got=%b want=%b", k, got, d_exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        apply(1'b0, 1'b1, 8'h11, 4'b0111);
        got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'b1_11_11_10_10) begin
            bad++;
            $display("FAIL b2b_first got=%b want=%b", got, 9'b1_11_11_10_10);
        end
        apply(1'b0, 1'b1, 8'h03, 4'b0001);
        got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'b1_01_01_01_01) begin
            bad++;
            $display("FAIL b2b_second got=%b want=%b", got, 9'b1_01_01_01_01);
        end
        // Idle with garbage on the data lines: result must hold, valid must drop
        apply(1'b0, 1'b0, 8'hF0, 4'b1000);
        total++;
        if (vif.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_valid got=%b want=0", vif.out_valid);
        end
        got = {1'b0, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'b0_01_01_01_01) begin
            bad++;
            $display("FAIL hold_data got=%b want=%b", got, 9'b0_01_01_01_01);
        end
    endtask

    task automatic test_reset_priority();
        logic [8:0] got;
        apply(1'b1, 1'b1, 8'h11, 4'b0111);
        got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'd0) begin
            bad++;
            $display("FAIL reset_priority got=%b want=%b", got, 9'd0);
        end
        apply(1'b0, 1'b1, 8'hF0, 4'b1000);
        got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
               vif.out_integer_count, vif.out_boolean_count};
        total++;
        if (got !== 9'b1_10_10_01_01) begin
            bad++;
            $display("FAIL after_reset got=%b want=%b", got, 9'b1_10_10_01_01);
        end
    endtask

    task automatic test_random();
        logic [7:0] iv;
        logic [3:0] bv;
        logic       r;
        logic       v;
        logic [8:0] got;
        logic [8:0] want;
        for (int n = 0; n < 300; n++) begin
            iv = 8'($urandom_range(0, 255));
            bv = 4'($urandom_range(0, 15));
            // Bias fields toward zero so absent slots are well exercised
            if ($urandom_range(0, 1) == 0) iv[3:0] = 4'h0;
            if ($urandom_range(0, 1) == 0) iv[7:4] = 4'h0;
            if ($urandom_range(0, 2) == 0) bv[1:0] = 2'b00;
            if ($urandom_range(0, 2) == 0) bv[3:2] = 2'b00;
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 2) != 0);
            apply(r, v, iv, bv);
            got = {vif.out_valid, vif.out_integer_variables, vif.out_boolean_variables,
                   vif.out_integer_count, vif.out_boolean_count};
            want = {m_valid, m_iv, m_bv, m_ic, m_bc};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random_%0d rst=%b v=%b int=%h bool=%b got=%b want=%b",
                         n, r, v, iv, bv, got, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        vif.in_valid = 1'b0;
        vif.in_integer_coefficients = '0;
        vif.in_boolean_coefficients = '0;
        m_valid = 1'b0;
        m_iv = '0;
        m_bv = '0;
        m_ic = '0;
        m_bc = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
